// File: rtl/dram_device.sv
// dram_device: single-bank DRAM model on the far side of the DRAM pin bus.
// Decodes RAS/CAS strobes, tracks the open row, applies byte-masked writes
// to an internal word array and returns read data after a fixed CAS latency.
//
// Bank FSM states:
//   state    | meaning
//   S_IDLE   | bank precharged, no open row; RD/WR are protocol errors
//   S_ACTIVE | row latched in r_row; RD/WR address that row, PRE closes it
module dram_device #(
   parameter int MEM_AW = 16,
   parameter int CL     = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        DRAM_CSn,
   input  logic        DRAM_RASn,
   input  logic        DRAM_CASn,
   input  logic [3:0]  DRAM_WEn,
   input  logic [10:0] DRAM_A,
   input  logic [31:0] DRAM_D,
   output logic [31:0] DRAM_Q,
   output logic        DRAM_valid,
   output logic        err
);

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [10:0] r_row;
   logic [10:0] w_row_nxt;
   logic        w_err_set;

   logic        w_sel;
   logic        w_we_all_hi;
   logic        w_act;
   logic        w_pre;
   logic        w_rd;
   logic        w_wr;
   logic        w_illegal;
   logic        w_rd_go;
   logic        w_wr_go;

   logic [20:0]        w_addr;
   logic [MEM_AW-1:0]  w_idx;
   logic               w_unused;

   logic [31:0] r_mem [0:(2**MEM_AW)-1];

   logic [CL-1:0] r_pipe_v;
   logic [31:0]   r_pipe_d [CL];

   // Command decode; CSn high forces every command to NOP.
   always_comb begin
      w_sel       = ~DRAM_CSn;
      w_we_all_hi = (DRAM_WEn == 4'hF);
      w_act       = w_sel & ~DRAM_RASn &  DRAM_CASn &  w_we_all_hi;
      w_pre       = w_sel & ~DRAM_RASn &  DRAM_CASn & ~w_we_all_hi;
      w_rd        = w_sel &  DRAM_RASn & ~DRAM_CASn &  w_we_all_hi;
      w_wr        = w_sel &  DRAM_RASn & ~DRAM_CASn & ~w_we_all_hi;
      w_illegal   = w_sel & ~DRAM_RASn & ~DRAM_CASn;
   end

   // Word index: row/column concatenation, upper bits alias away; A[10] unused on CAS.
   assign w_addr   = {r_row, DRAM_A[9:0]};
   assign w_idx    = w_addr[MEM_AW-1:0];
   assign w_unused = ^{DRAM_A[10], w_addr[20:MEM_AW]};

   // Next-state, row latch and error detection for the bank.
   always_comb begin
      w_state_nxt = r_state;
      w_row_nxt   = r_row;
      w_err_set   = w_illegal;
      w_rd_go     = 1'b0;
      w_wr_go     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_act) begin
               w_state_nxt = S_ACTIVE;
               w_row_nxt   = DRAM_A;
            end
            if (w_rd || w_wr) w_err_set = 1'b1;
         end
         S_ACTIVE: begin
            w_rd_go = w_rd;
            w_wr_go = w_wr;
            if (w_pre) w_state_nxt = S_IDLE;
            if (w_act) w_err_set = 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Bank state, open row and sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_row   <= 11'h000;
         err     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_row   <= w_row_nxt;
         if (w_err_set) err <= 1'b1;
      end
   end

   // Byte-masked array write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (w_wr_go) begin
         for (int i = 0; i < 4; i++) begin
            if (!DRAM_WEn[i]) r_mem[w_idx][8*i +: 8] <= DRAM_D[8*i +: 8];
         end
      end
   end

   // CAS-latency pipeline: stage 0 captures the word at the RD edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pipe_v <= '0;
         for (int k = 0; k < CL; k++) r_pipe_d[k] <= 32'h0;
      end else begin
         r_pipe_v[0] <= w_rd_go;
         r_pipe_d[0] <= r_mem[w_idx];
         for (int k = 1; k < CL; k++) begin
            r_pipe_v[k] <= r_pipe_v[k-1];
            r_pipe_d[k] <= r_pipe_d[k-1];
         end
      end
   end

   // Registered read port; Q holds the last delivered beat between pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         DRAM_Q     <= 32'h0;
         DRAM_valid <= 1'b0;
      end else begin
         DRAM_valid <= r_pipe_v[CL-1];
         if (r_pipe_v[CL-1]) DRAM_Q <= r_pipe_d[CL-1];
      end
   end

endmodule

// File: tb/tb_dram_device.sv
// Directed testbench for dram_device.
module tb_dram_device;

   localparam int CL = 5;

   logic        clk;
   logic        rst_n;
   logic        DRAM_CSn;
   logic        DRAM_RASn;
   logic        DRAM_CASn;
   logic [3:0]  DRAM_WEn;
   logic [10:0] DRAM_A;
   logic [31:0] DRAM_D;
   logic [31:0] DRAM_Q;
   logic        DRAM_valid;
   logic        err;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   int          vq_cyc[$];
   logic [31:0] vq_dat[$];

   dram_device #(.MEM_AW(16), .CL(CL)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .DRAM_CSn  (DRAM_CSn),
      .DRAM_RASn (DRAM_RASn),
      .DRAM_CASn (DRAM_CASn),
      .DRAM_WEn  (DRAM_WEn),
      .DRAM_A    (DRAM_A),
      .DRAM_D    (DRAM_D),
      .DRAM_Q    (DRAM_Q),
      .DRAM_valid(DRAM_valid),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Log every read beat with the edge count it appeared after.
   always @(negedge clk) begin
      if (DRAM_valid === 1'b1) begin
         vq_cyc.push_back(cyc);
         vq_dat.push_back(DRAM_Q);
      end
   end

   task automatic drive_nop();
      DRAM_CSn  = 1'b0;
      DRAM_RASn = 1'b1;
      DRAM_CASn = 1'b1;
      DRAM_WEn  = 4'hF;
      DRAM_A    = 11'h0;
      DRAM_D    = 32'h0;
   endtask

   // Present one command for exactly one rising edge, then return to NOP.
   task automatic cmd(input logic csn, input logic rasn, input logic casn,
                      input logic [3:0] wen, input logic [10:0] a, input logic [31:0] d);
      @(negedge clk);
      DRAM_CSn  = csn;
      DRAM_RASn = rasn;
      DRAM_CASn = casn;
      DRAM_WEn  = wen;
      DRAM_A    = a;
      DRAM_D    = d;
      @(posedge clk);
      #1;
      drive_nop();
   endtask

   task automatic act(input logic [10:0] row); cmd(1'b0, 1'b0, 1'b1, 4'hF, row, 32'h0); endtask
   task automatic pre();                       cmd(1'b0, 1'b0, 1'b1, 4'h0, 11'h0, 32'h0); endtask
   task automatic wr(input logic [10:0] a, input logic [31:0] d, input logic [3:0] wen);
      cmd(1'b0, 1'b1, 1'b0, wen, a, d);
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      drive_nop();
      rst_n = 1'b0;
      wait_cycles(2);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Single read: exactly one beat, exactly CL edges after the RD edge.
   task automatic rd_check(input string name, input logic [10:0] a, input logic [31:0] exp);
      int e;
      vq_cyc.delete();
      vq_dat.delete();
      cmd(1'b0, 1'b1, 1'b0, 4'hF, a, 32'h0);
      e = cyc;
      wait_cycles(CL + 2);
      checks++;
      if (vq_cyc.size() !== 1) begin
         errors++;
         $display("FAIL %s beat_count: got %0d want 1", name, vq_cyc.size());
      end else begin
         checks++;
         if (vq_cyc[0] !== e + CL) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, vq_cyc[0] - e, CL);
         end
         checks++;
         if (vq_dat[0] !== exp) begin
            errors++;
            $display("FAIL %s data: got %h want %h", name, vq_dat[0], exp);
         end
      end
   endtask

   task automatic check_err(input string name, input logic exp);
      checks++;
      if (err !== exp) begin
         errors++;
         $display("FAIL %s err: got %b want %b", name, err, exp);
      end
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if (DRAM_Q !== 32'h0) begin
         errors++;
         $display("FAIL reset_q: got %h want 00000000", DRAM_Q);
      end
      checks++;
      if (DRAM_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b want 0", DRAM_valid);
      end
      check_err("reset", 1'b0);
   endtask

   task automatic test_basic();
      act(11'h005);
      wr(11'h010, 32'hDEADBEEF, 4'h0);
      rd_check("basic_rd", 11'h010, 32'hDEADBEEF);
      check_err("basic", 1'b0);
   endtask

   task automatic test_byte_mask();
      wr(11'h020, 32'h11223344, 4'h0);
      wr(11'h020, 32'hAABBCCDD, 4'b1010);
      rd_check("byte_mask", 11'h020, 32'h11BB33DD);
   endtask

   task automatic test_back_to_back();
      int e0;
      for (int i = 0; i < 4; i++) wr(11'(i), 32'(i), 4'h0);
      vq_cyc.delete();
      vq_dat.delete();
      cmd(1'b0, 1'b1, 1'b0, 4'hF, 11'h000, 32'h0);
      e0 = cyc;
      cmd(1'b0, 1'b1, 1'b0, 4'hF, 11'h001, 32'h0);
      cmd(1'b0, 1'b1, 1'b0, 4'hF, 11'h002, 32'h0);
      cmd(1'b0, 1'b1, 1'b0, 4'hF, 11'h003, 32'h0);
      pre();
      wait_cycles(CL + 4);
      checks++;
      if (vq_cyc.size() !== 4) begin
         errors++;
         $display("FAIL burst_count: got %0d want 4", vq_cyc.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (vq_cyc[i] !== e0 + CL + i || vq_dat[i] !== 32'(i)) begin
               errors++;
               $display("FAIL burst_beat%0d: got cyc+%0d data %h want cyc+%0d data %h",
                        i, vq_cyc[i] - e0, vq_dat[i], CL + i, 32'(i));
            end
         end
      end
      checks++;
      if (DRAM_Q !== 32'h3 || DRAM_valid !== 1'b0) begin
         errors++;
         $display("FAIL burst_hold: got q=%h valid=%b want q=00000003 valid=0", DRAM_Q, DRAM_valid);
      end
      // Bank must be IDLE after PRE: a fresh ACT is legal there.
      act(11'h005);
      check_err("burst_pre_idle", 1'b0);
   endtask

   task automatic test_csn();
      wr(11'h030, 32'h12345678, 4'h0);
      cmd(1'b1, 1'b1, 1'b0, 4'h0, 11'h030, 32'hFFFFFFFF);
      cmd(1'b1, 1'b0, 1'b0, 4'hF, 11'h030, 32'h0);
      rd_check("csn_masked", 11'h030, 32'h12345678);
      check_err("csn", 1'b0);
   endtask

   task automatic test_alias();
      wr(11'h411, 32'h5555AAAA, 4'h0);
      rd_check("a10_ignored", 11'h011, 32'h5555AAAA);
      pre();
      act(11'h045);
      rd_check("row_alias", 11'h010, 32'hDEADBEEF);
      pre();
      check_err("alias", 1'b0);
   endtask

   task automatic test_reset_mid();
      act(11'h005);
      vq_cyc.delete();
      vq_dat.delete();
      cmd(1'b0, 1'b1, 1'b0, 4'hF, 11'h010, 32'h0);
      wait_cycles(2);
      rst_n = 1'b0;
      #1;
      checks++;
      if (DRAM_Q !== 32'h0 || DRAM_valid !== 1'b0) begin
         errors++;
         $display("FAIL midrst_outputs: got q=%h valid=%b want q=00000000 valid=0", DRAM_Q, DRAM_valid);
      end
      wait_cycles(2);
      @(negedge clk);
      rst_n = 1'b1;
      wait_cycles(CL + 3);
      checks++;
      if (vq_cyc.size() !== 0) begin
         errors++;
         $display("FAIL midrst_flush: got %0d beats want 0", vq_cyc.size());
      end
      act(11'h005);
      rd_check("midrst_after", 11'h010, 32'hDEADBEEF);
      check_err("midrst", 1'b0);
   endtask

   task automatic test_errors();
      do_reset();
      vq_cyc.delete();
      vq_dat.delete();
      cmd(1'b0, 1'b1, 1'b0, 4'hF, 11'h010, 32'h0);
      check_err("rd_idle_rise", 1'b1);
      wait_cycles(CL + 3);
      checks++;
      if (vq_cyc.size() !== 0) begin
         errors++;
         $display("FAIL rd_idle_beats: got %0d want 0", vq_cyc.size());
      end
      check_err("rd_idle_sticky", 1'b1);

      do_reset();
      act(11'h005);
      check_err("act_once", 1'b0);
      act(11'h007);
      check_err("act_act", 1'b1);
      rd_check("act_act_row", 11'h010, 32'hDEADBEEF);

      do_reset();
      check_err("ill_before", 1'b0);
      cmd(1'b0, 1'b0, 1'b0, 4'hF, 11'h000, 32'h0);
      check_err("ras_cas_low", 1'b1);
      wait_cycles(3);
      check_err("ras_cas_sticky", 1'b1);
   endtask

   initial begin
      drive_nop();
      rst_n = 1'b1;
      #2;
      test_reset();
      test_basic();
      test_byte_mask();
      test_back_to_back();
      test_csn();
      test_alias();
      test_reset_mid();
      test_errors();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dram_device.md
# dram_device

Cycle-based, synthesizable DRAM device model that sits on the far side of the DRAM pin interface (`DRAM_CSn/WEn/RASn/CASn/A/D` in, `DRAM_Q/DRAM_valid` out) and answers the commands issued by the AXI-to-DRAM wrapper. It decodes RAS/CAS command strobes, tracks the open row, performs byte-masked writes into an internal word array and returns read data through a fixed CAS-latency pipeline. A sticky protocol-error flag gives the testbench a single observable for illegal command sequences.

## Interface
- `MEM_AW`, 16, log2 of stored words; word index = low `MEM_AW` bits of `{row[10:0], col[9:0]}`
- `CL`, 5, CAS latency in cycles (legal range 1..8)
- `clk` input 1 — single clock, all state on rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `DRAM_CSn` input 1 — chip select, active low; high = all inputs ignored
- `DRAM_RASn` input 1 — row strobe, active low
- `DRAM_CASn` input 1 — column strobe, active low
- `DRAM_WEn` input 4 — per-byte write enable, active low; also selects ACT vs PRE
- `DRAM_A` input 11 — row address on RAS, `{x, col[9:0]}` on CAS
- `DRAM_D` input 32 — write data
- `DRAM_Q` output 32 — read data
- `DRAM_valid` output 1 — one-cycle pulse per read beat
- `err` output 1 — sticky protocol error

## Operation
- Command decode, sampled each rising edge when `DRAM_CSn`=0:
  - ACT: `RASn`=0, `CASn`=1, `WEn`=4'hF
  - PRE: `RASn`=0, `CASn`=1, `WEn`≠4'hF (wrapper drives 4'h0)
  - RD: `RASn`=1, `CASn`=0, `WEn`=4'hF
  - WR: `RASn`=1, `CASn`=0, `WEn`≠4'hF
  - NOP: `RASn`=1, `CASn`=1
  - `RASn`=0 and `CASn`=0: illegal; set `err`, no state change
- Bank FSM, two states:
  - IDLE (precharged): ACT → latch `row`=`DRAM_A`, go ACTIVE. PRE → no-op, no error. RD/WR → set `err`, ignored (no write, no valid).
  - ACTIVE: RD/WR use latched `row`, stay ACTIVE. PRE → IDLE. ACT → set `err`, row unchanged, stay ACTIVE.
- WR: for each byte i with `WEn[i]`=0, `mem[idx][8i+7:8i]` ← `DRAM_D[8i+7:8i]`; other bytes kept. `DRAM_A[10]` ignored.
- RD: `mem[idx]` captured at the CAS edge into a CL-deep pipeline (data + valid bit per stage); one RD accepted per cycle, back-to-back reads legal.
- A WR in cycle t is visible to an RD in cycle t+1.
- Address above 2^MEM_AW words aliases (upper bits dropped); no error.
- Array contents are not affected by reset; uninitialised words read as X in simulation.

## Timing
- Reset values: `DRAM_Q`=32'h0, `DRAM_valid`=0, `err`=0, FSM=IDLE, `row`=0, all pipeline valid bits 0.
- RD sampled at edge t → `DRAM_valid`=1 and `DRAM_Q`=data during cycle t+CL (registered outputs), for exactly one cycle per RD.
- `DRAM_Q` holds last delivered data while `DRAM_valid`=0.
- ACT/PRE/WR take effect at the sampling edge; next command may follow in the next cycle (no tRCD/tRP enforcement).
- PRE while reads are in flight: pipeline drains normally; data already captured.
- `err` rises the cycle after the offending edge, stays 1 until `rst_n`.
- Reset mid-operation: pipeline flushed immediately, no pending `DRAM_valid` pulses after release, FSM IDLE.
- `DRAM_CSn`=1 during a cycle: treated as NOP regardless of other inputs; in-flight reads still complete.

## Test plan
- ACT row 11'h005, WR col 10'h010 `D`=32'hDEADBEEF `WEn`=4'h0, RD col 10'h010 → `DRAM_valid` pulse exactly CL=5 cycles after RD, `DRAM_Q`=32'hDEADBEEF, `err`=0.
- Byte mask: word preloaded 32'h11223344, WR `D`=32'hAABBCCDD `WEn`=4'b1010 → RD returns 32'h11BB33DD.
- Burst: four consecutive-cycle RDs cols 0..3 holding 32'h0,1,2,3 → four consecutive `DRAM_valid` cycles with Q 0,1,2,3, then PRE issued one cycle after last RD → all four still delivered, FSM IDLE.
- Protocol errors: RD in IDLE → no valid pulse, `err`=1; after reset, ACT then ACT → `err`=1, row keeps first value; `RASn`=`CASn`=0 → `err`=1.
- `DRAM_CSn`=1 with WR pattern to a word holding 32'h12345678 → word unchanged on later RD, `err`=0.
- Assert `rst_n`=0 two cycles after an RD with CL=5 → no `DRAM_valid` ever seen for it; outputs 0; subsequent ACT/RD sequence works normally.
